// File: rtl/fsm_out_deser.sv
// Deserializes the Mealy FSM's y_out stream into WIDTH-bit MSB-first words behind a
// registered valid/ready port with a sticky overrun flag. Define DESER_ONES_COUNT_EN to add ones_cnt.
module fsm_out_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             bit_en,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
`ifdef DESER_ONES_COUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
`endif
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(WIDTH+1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             load;

  always_comb begin
    word  = {sr_q, y_in};
    done  = bit_en && (cnt_q == CW'(WIDTH-1));
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bit_en) begin
      sr_d  = word[WIDTH-2:0];
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end

    state_d = state_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (done) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        // A consume on the completing edge frees the slot, so the new word replaces it.
        if (data_ready) begin
          if (done) load = 1'b1;
          else      state_d = EMPTY;
        end else if (done) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase

    data_d = load ? word : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = (state_q == FULL);
  assign overrun    = ovr_q;

`ifdef DESER_ONES_COUNT_EN
  logic [OW-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (load) begin
      ones_d = '0;
      for (int i = 0; i < WIDTH; i++) ones_d = ones_d + OW'(word[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ones_q <= '0;
    else       ones_q <= ones_d;
  end

  assign ones_cnt = ones_q;
`endif

endmodule

// File: tb/tb_fsm_out_deser.sv
// Bench for fsm_out_deser: directed vector table, hand-written corner sequences,
// then randomized traffic against a word-level reference model.
module tb_fsm_out_deser;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, y_in, bit_en, data_ready;
  logic [W-1:0] data_out;
  logic         data_valid, overrun;
`ifdef DESER_ONES_COUNT_EN
  logic [$clog2(W+1)-1:0] ones_cnt;
`endif

  fsm_out_deser #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .bit_en(bit_en), .data_ready(data_ready),
    .data_out(data_out), .data_valid(data_valid),
`ifdef DESER_ONES_COUNT_EN
    .ones_cnt(ones_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: collects bits until a word is complete, then applies the handshake rules.
  int          m_nb;
  logic [31:0] m_acc;
  logic        m_valid, m_ovr;
  logic [W-1:0] m_data;

  function automatic void model_step(input bit rst, input bit y, input bit en, input bit rdy);
    bit          complete;
    logic [W-1:0] w;
    complete = 0;
    w = '0;
    if (rst) begin
      m_nb = 0; m_acc = 0; m_valid = 0; m_ovr = 0; m_data = '0;
      return;
    end
    if (en) begin
      m_acc = m_acc * 2 + 32'(y);
      m_nb++;
      if (m_nb == W) begin
        complete = 1; w = m_acc[W-1:0]; m_nb = 0; m_acc = 0;
      end
    end
    if (!m_valid) begin
      if (complete) begin m_valid = 1; m_data = w; end
    end else if (rdy) begin
      if (complete) m_data = w;
      else          m_valid = 0;
    end else if (complete) begin
      m_ovr = 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit y, input bit en, input bit rdy);
    reset = rst; y_in = y; bit_en = en; data_ready = rdy;
    @(posedge clk);
    model_step(rst, y, en, rdy);
    #1;
  endtask

  task automatic check_outputs(input string tag, input bit v, input logic [W-1:0] d, input bit o);
    check({tag, ".valid"}, 32'(data_valid), 32'(v));
    check({tag, ".data"}, 32'(data_out), 32'(d));
    check({tag, ".overrun"}, 32'(overrun), 32'(o));
`ifdef DESER_ONES_COUNT_EN
    check({tag, ".ones"}, 32'(ones_cnt), 32'($countones(d)));
`endif
  endtask

  typedef struct {
    bit rst, y, en, rdy;
    bit ev;
    logic [W-1:0] ed;
    bit eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input bit y, input bit en, input bit rdy,
                              input bit ev, input logic [W-1:0] ed, input bit eo);
    vec_t v;
    v.rst = rst; v.y = y; v.en = en; v.rdy = rdy; v.ev = ev; v.ed = ed; v.eo = eo;
    tbl.push_back(v);
  endfunction

  // Adds the 8 bits of a word; rdy applies to all bits, expectations given before/at the last bit.
  function automatic void add_word(input logic [W-1:0] w, input bit rdy,
                                   input bit pv, input logic [W-1:0] pd, input bit po,
                                   input bit lv, input logic [W-1:0] ld, input bit lo);
    for (int i = W-1; i >= 0; i--) begin
      if (i == 0) add(0, w[i], 1, rdy, lv, ld, lo);
      else        add(0, w[i], 1, rdy, pv, pd, po);
    end
  endfunction

  initial begin
    reset = 1; y_in = 0; bit_en = 0; data_ready = 0;
    m_nb = 0; m_acc = 0; m_valid = 0; m_ovr = 0; m_data = '0;

    // Reset held 2 cycles with bit_en high, then the FSM stream 1,0,1,1,1,0,1,1.
    add(1, 1, 1, 1, 0, 8'h00, 0);
    add(1, 0, 1, 1, 0, 8'h00, 0);
    add_word(8'hBB, 1, 0, 8'h00, 0, 1, 8'hBB, 0);
    add(0, 0, 0, 1, 0, 8'hBB, 0);
    // Backpressure: A5 held while 3C is dropped, then one ready cycle drains it.
    add_word(8'hA5, 0, 0, 8'hBB, 0, 1, 8'hA5, 0);
    add_word(8'h3C, 0, 1, 8'hA5, 0, 1, 8'hA5, 1);
    add(0, 0, 0, 1, 0, 8'hA5, 1);
    add(0, 0, 0, 0, 0, 8'hA5, 1);
    add(1, 0, 0, 0, 0, 8'h00, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].y, tbl[k].en, tbl[k].rdy);
      check_outputs($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ed, tbl[k].eo);
    end

    // Gapped enable: bits only on even cycles, word appears on cycle 16.
    begin
      logic [W-1:0] w = 8'hBB;
      int early = 0;
      int b = W-1;
      for (int c = 1; c <= 16; c++) begin
        if (c % 2 == 0) begin drive(0, w[b], 1, 1); b--; end
        else            drive(0, 0, 0, 1);
        if (c < 16 && data_valid) early++;
      end
      check("gap.early_valid", 32'(early), 0);
      check_outputs("gap.word", 1, 8'hBB, 0);
    end

    // Consume and complete on the same edge.
    drive(1, 0, 0, 0);
    begin
      logic [W-1:0] w0 = 8'h0F;
      logic [W-1:0] w1 = 8'hF0;
      for (int i = W-1; i >= 0; i--) drive(0, w0[i], 1, 0);
      check_outputs("simul.hold", 1, 8'h0F, 0);
      for (int i = W-1; i >= 0; i--) drive(0, w1[i], 1, (i == 0));
      check_outputs("simul.replace", 1, 8'hF0, 0);
    end

    // Reset mid-word discards the partial bits.
    begin
      logic [W-1:0] w = 8'h81;
      for (int i = 0; i < 5; i++) drive(0, 1, 1, 1);
      drive(1, 0, 0, 1);
      check_outputs("midrst.reset", 0, 8'h00, 0);
      for (int i = W-1; i >= 0; i--) drive(0, w[i], 1, 1);
      check_outputs("midrst.word", 1, 8'h81, 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bit r  = ($urandom_range(99) == 0);
      bit y  = 1'($urandom);
      bit en = ($urandom_range(9) < 7);
      bit rd = ($urandom_range(9) < 4);
      drive(r, y, en, rd);
      check_outputs($sformatf("rand%0d", c), m_valid, m_data, m_ovr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
